// File: rtl/tff_pkg.sv
// Shared definitions for the toggle-cell counter family.
//   CNT_UP / CNT_DN : encodings of the 'up' direction input
//   clamp_load()    : saturates a parallel-load value into 0..modulus-1,
//                     also used by the divider blocks
package tff_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Values at or above the modulus saturate to the top legal count.
  function automatic int unsigned clamp_load(input int unsigned d,
                                             input int unsigned modulus);
    return (d < modulus) ? d : modulus - 1;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit T flip-flop used as the storage cell of the counters.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (q -> 0), wins over pre_n
//   pre_n : asynchronous active-low preset (q -> 1)
//   t     : toggle enable, q inverts on the clock edge when t = 1
//   q     : registered cell output
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic pre_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n or negedge pre_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (!pre_n) begin
      q <= 1'b1;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_mod_counter.sv
// Synchronous modulo-MODULUS up/down counter made of one tff_cell per bit.
// All cells share CLK, so every bit changes on the same edge.
//   CLK      : rising-edge clock
//   rst      : asynchronous active-low reset
//   en       : count enable (cascade input)
//   up       : 1 = count up, 0 = count down
//   load     : synchronous parallel load, highest priority
//   d        : load value (clamped to MODULUS-1)
//   q        : current count
//   tc_out   : combinational terminal count for cascading into the next en
//   tc_q     : registered one-cycle pulse on the wrapping edge
//   load_err : registered one-cycle pulse when a load value was clamped
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc_out,
  output logic             tc_q,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t_vec;
  logic             load_clamped;

  assign load_clamped = (32'(d) >= MODULUS);

  // Wrap compares are done at 32 bits so an out-of-range held count
  // (only reachable through a bad parameter set) still steps back into range.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = WIDTH'(clamp_load(32'(d), MODULUS));
    end else if (en) begin
      if (up == CNT_UP) begin
        q_next = (32'(q) >= MODULUS - 1) ? '0 : q + 1'b1;
      end else begin
        q_next = ((q == '0) || (32'(q) >= MODULUS)) ? MAX_Q : q - 1'b1;
      end
    end
  end

  assign tc_out = en & ~load & ((up == CNT_DN) ? (q == '0) : (q == MAX_Q));

  // Each cell toggles exactly where the next state differs from the current one.
  assign t_vec = q_next ^ q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (CLK),
      .rst_n (rst),
      .pre_n (1'b1),
      .t     (t_vec[i]),
      .q     (q[i])
    );
  end

  // tc_out is already gated by en and ~load, so it covers the load and hold cases.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      tc_q     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tc_q     <= tc_out;
      load_err <= load & load_clamped;
    end
  end

endmodule

// File: tb/tb_tff_mod_counter.sv
module tb_tff_mod_counter;

  logic       CLK;
  logic       rst;
  logic       en, up, load;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc_out, tc_q, load_err;

  // natural-binary instance (MODULUS == 2**WIDTH)
  logic       b_en, b_up, b_load;
  logic [3:0] b_d, b_q;
  logic       b_tc_out, b_tc_q, b_load_err;

  // two-digit cascade
  logic       c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc_out, lo_tc_q, lo_load_err;
  logic       hi_tc_out, hi_tc_q, hi_load_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK(CLK), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q), .tc_out(tc_out), .tc_q(tc_q), .load_err(load_err)
  );

  tff_mod_counter #(.WIDTH(4), .MODULUS(16)) dut_bin (
    .CLK(CLK), .rst(rst), .en(b_en), .up(b_up), .load(b_load), .d(b_d),
    .q(b_q), .tc_out(b_tc_out), .tc_q(b_tc_q), .load_err(b_load_err)
  );

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (
    .CLK(CLK), .rst(rst), .en(c_en), .up(1'b1), .load(1'b0), .d(4'd0),
    .q(lo_q), .tc_out(lo_tc_out), .tc_q(lo_tc_q), .load_err(lo_load_err)
  );

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
    .CLK(CLK), .rst(rst), .en(lo_tc_out), .up(1'b1), .load(1'b0), .d(4'd0),
    .q(hi_q), .tc_out(hi_tc_out), .tc_q(hi_tc_q), .load_err(hi_load_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then sample 2 time units later
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
    b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_d = 4'd0;
    c_en = 1'b0;

    // reset state
    #3;
    check("rst_q", 32'(q), 32'd0);
    check("rst_tc_q", 32'(tc_q), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    #9 rst = 1'b1;                         // t=12, away from edges

    // reach q=7 mid-count, then async reset
    load = 1'b1; en = 1'b1; d = 4'd6;
    tick();                                // load wins over en
    check("mid_load6", 32'(q), 32'd6);
    load = 1'b0;
    tick();
    check("mid_q7", 32'(q), 32'd7);
    #2 rst = 1'b0;
    #1;
    check("async_rst_q", 32'(q), 32'd0);
    check("async_rst_tc_q", 32'(tc_q), 32'd0);
    check("async_rst_load_err", 32'(load_err), 32'd0);
    tick();
    check("rst_held_q", 32'(q), 32'd0);
    en = 1'b0;
    #3 rst = 1'b1;

    // up wrap from 0, 12 edges
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      check("up_tc_out", 32'(tc_out), 32'(((k - 1) % 10) == 9));
      tick();
      check("up_q", 32'(q), 32'(k % 10));
      check("up_tc_q", 32'(tc_q), 32'(k == 10));
    end

    // down wrap
    en = 1'b0; load = 1'b1; d = 4'd1;
    tick();
    load = 1'b0;
    check("dn_load1", 32'(q), 32'd1);
    en = 1'b1; up = 1'b0;
    #1;
    check("dn_tc_out_q1", 32'(tc_out), 32'd0);
    tick();
    check("dn_q0", 32'(q), 32'd0);
    check("dn_tc_out_q0", 32'(tc_out), 32'd1);
    tick();
    check("dn_q9", 32'(q), 32'd9);
    check("dn_tc_q_wrap", 32'(tc_q), 32'd1);
    check("dn_tc_out_q9", 32'(tc_out), 32'd0);
    tick();
    check("dn_q8", 32'(q), 32'd8);
    check("dn_tc_q_after", 32'(tc_q), 32'd0);

    // load priority and clamp
    load = 1'b1; en = 1'b1; up = 1'b1; d = 4'd4;
    tick();
    check("ld4_q", 32'(q), 32'd4);
    check("ld4_err", 32'(load_err), 32'd0);
    d = 4'd13;
    tick();
    check("ld13_q", 32'(q), 32'd9);
    check("ld13_err", 32'(load_err), 32'd1);
    check("ld_tc_out_masked", 32'(tc_out), 32'd0);
    load = 1'b0; en = 1'b0;
    tick();
    check("ld_err_clear", 32'(load_err), 32'd0);
    check("ld_hold_q", 32'(q), 32'd9);

    // hold
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_q", 32'(q), 32'd9);
      check("hold_tc_q", 32'(tc_q), 32'd0);
    end
    check("hold_tc_out", 32'(tc_out), 32'd0);

    // direction flip on the terminal cycle
    en = 1'b1; up = 1'b1;
    #1;
    check("flip_tc_out_up", 32'(tc_out), 32'd1);
    up = 1'b0;
    #1;
    check("flip_tc_out_dn", 32'(tc_out), 32'd0);
    tick();
    check("flip_q8", 32'(q), 32'd8);
    check("flip_tc_q", 32'(tc_q), 32'd0);
    en = 1'b0;

    // natural binary wrap, MODULUS=16
    b_load = 1'b1; b_d = 4'd15;
    tick();
    check("bin_ld15_q", 32'(b_q), 32'd15);
    check("bin_ld15_err", 32'(b_load_err), 32'd0);
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
    #1;
    check("bin_tc_out", 32'(b_tc_out), 32'd1);
    tick();
    check("bin_wrap_q", 32'(b_q), 32'd0);
    check("bin_wrap_tc_q", 32'(b_tc_q), 32'd1);
    b_up = 1'b0;
    tick();
    check("bin_dn_q", 32'(b_q), 32'd15);
    b_en = 1'b0;

    // two-digit cascade, 100 edges
    check("cas_start", 32'(hi_q) * 10 + 32'(lo_q), 32'd0);
    c_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("cas_value", 32'(hi_q) * 10 + 32'(lo_q), 32'(k % 100));
      check("cas_hi_tc_q", 32'(hi_tc_q), 32'(k == 100));
    end
    c_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
